reg_dump: RTL and testbench
===========================

Name: reg_dump

Overview:
- Debug read-out engine for the ID-stage register file; it is the reader counterpart to the clocked write port.
- On a start command it walks a contiguous, wrapping range of X0..X31 through a spare combinational read port.
- Each value is streamed out as a valid/ready beat tagged with its register index.
- Used by the debug/trace path and testbenches to snapshot architectural state without stalling the write-back port.

Parameters:
DATA_W, `WORD (64), register data width.
ZERO_X31, 1, when 1 the beat for index 31 carries all-zero data (XZR semantics) regardless of rd_data.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  reset, synchronous, active-high.
start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
first_reg  input  5  first register index; sampled when start is accepted.
last_reg  input  5  last register index; sampled when start is accepted.
abort  input  1  synchronous cancel of a dump in progress.
rd_addr  output  5  read address to register file port; equals internal index register.
rd_data  input  DATA_W  combinational read data for rd_addr, same cycle.
m_valid  output  1  output beat valid.
m_ready  input  1  consumer ready.
m_idx  output  5  register index of the current beat.
m_data  output  DATA_W  register value of the current beat.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse after the final beat handshakes.

Behaviour:
- Reset values: state=IDLE, idx=0, rd_addr=0, m_valid=0, m_idx=0, m_data=0, busy=0, done=0. Reset mid-dump discards the transfer; no done pulse.
- Handshake: a beat transfers on any cycle with m_valid&&m_ready.
  - While m_valid=1 and m_ready=0, m_idx and m_data are held stable.
  - m_valid never drops without a transfer, except on abort or rst.
- Range and count:
  - Beat count N = ((last_reg - first_reg) mod 32) + 1, range 1..32.
  - Indices run first, first+1, ... with 31 wrapping to 0.
  - first_reg > last_reg wraps; for example first=30, last=1 gives 30,31,0,1.
  - first_reg == last_reg gives a single beat.
  - A full 32-register dump uses first=0, last=31 (or any first with last = first-1).
- States:
  - IDLE: busy=0. On start, latch idx=first_reg, remaining=N-1, then go to FETCH.
  - FETCH (exactly one cycle):
    - rd_addr=idx.
    - Register m_data=rd_data (or 0 if ZERO_X31 && idx==31) and m_idx=idx.
    - Set m_valid=1, idx=idx+1 mod 32, then go to SEND.
  - SEND: rd_addr=idx, pointing at the next register.
    - On transfer with remaining>0: load m_data/m_idx from the current rd_data/idx in the same cycle, increment idx, decrement remaining, keep m_valid=1.
    - On transfer with remaining==0: m_valid=0 next cycle, done=1 for one cycle, go to IDLE.
- Latency and throughput:
  - start at cycle T gives FETCH at T+1 and the first m_valid at T+2.
  - With m_ready held high, N beats arrive on N consecutive cycles and done is asserted at T+2+N.
- Snapshot semantics: each value is the register contents on the cycle it is sampled.
  - For the first beat this is the FETCH cycle; for later beats it is the preceding handshake cycle.
  - Register-file writes landing before that edge are visible; later writes are not. There is no global atomicity.
- Boundary conditions:
  - start while busy: ignored, no effect on the range.
  - start and abort together in IDLE: start wins.
  - abort in FETCH or SEND: next cycle state=IDLE, m_valid=0, done=0. A transfer in the abort cycle still counts as delivered.
  - abort in IDLE: no effect.
  - done and a new start in the same cycle: start is accepted, since the state is already IDLE.
  - rd_addr in IDLE holds its last value; this is don't-care for the register file.

Test Plan:
- Full dump: preload Xi=0x1000+i, start with first=0, last=31, m_ready=1 → 32 beats on consecutive cycles, m_idx 0..31, m_data 0x1000..0x101E, index 31 data=0 (ZERO_X31=1), done one cycle after the last beat.
- Backpressure: first=4, last=7, m_ready toggling 1,0,0,1,... → exactly 4 beats (idx 4,5,6,7), m_data/m_idx stable while stalled, no duplicate or dropped beat.
- Wrap and single: first=30, last=1 → idx 30,31,0,1 then done. first=last=5 → one beat with X5, then done.
- Write during dump: first=0, last=3, m_ready=0 for 3 cycles after the first beat, X2 written to 0xDEAD during the stall → beat idx2 carries 0xDEAD.
- Abort and re-start: abort after 2 of 8 beats → m_valid=0 next cycle, no done, busy=0. A start issued while busy is ignored. A new start afterwards dumps its full range correctly.
- Reset mid-dump: assert rst during SEND → all outputs at reset values on the next cycle; a subsequent dump behaves normally.

Source files
------------

// File: rtl/reg_dump.sv
// Debug read-out engine: walks a wrapping range of X0..X31 through a spare
// combinational read port and streams each value as an indexed valid/ready beat.
module reg_dump #(
    parameter int DATA_W   = 64,
    parameter bit ZERO_X31 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        first_reg,
    input  logic [4:0]        last_reg,
    input  logic              abort,
    output logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [4:0]        m_idx,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start; rd_addr holds its last value
    // FETCH | one cycle: capture the first register into the output beat
    // SEND  | beat valid; each handshake reloads from the next register
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t            state, state_nxt;
    logic [4:0]        idx, idx_nxt;
    logic [4:0]        remaining, remaining_nxt;
    logic [4:0]        m_idx_nxt;
    logic              m_valid_nxt, done_nxt;
    logic [DATA_W-1:0] m_data_nxt;
    logic [DATA_W-1:0] rd_value;
    logic              xfer;

    // X31 reads as the zero register when enabled
    assign rd_value = (ZERO_X31 && idx == 5'd31) ? '0 : rd_data;
    assign rd_addr  = idx;
    assign busy     = (state != IDLE);
    assign xfer     = m_valid && m_ready;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        m_idx_nxt     = m_idx;
        m_data_nxt    = m_data;
        m_valid_nxt   = m_valid;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt       = first_reg;
                    remaining_nxt = last_reg - first_reg;
                    state_nxt     = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    m_valid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    m_data_nxt  = rd_value;
                    m_idx_nxt   = idx;
                    m_valid_nxt = 1'b1;
                    idx_nxt     = idx + 5'd1;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    m_valid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else if (xfer) begin
                    if (remaining != 5'd0) begin
                        m_data_nxt    = rd_value;
                        m_idx_nxt     = idx;
                        idx_nxt       = idx + 5'd1;
                        remaining_nxt = remaining - 5'd1;
                    end else begin
                        m_valid_nxt = 1'b0;
                        done_nxt    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: begin
                m_valid_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            m_idx     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
            m_idx     <= m_idx_nxt;
            m_data    <= m_data_nxt;
            m_valid   <= m_valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: register-file array drives rd_data; a range/snapshot
// model predicts each beat under random data, ranges and backpressure.
module tb_reg_dump;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst, start, abort, m_ready;
    logic [4:0]    first_reg, last_reg;
    logic [4:0]    rd_addr, m_idx;
    logic [DW-1:0] rd_data, m_data;
    logic          m_valid, busy, done;

    logic [DW-1:0] regs [32];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;
    assign rd_data = regs[rd_addr];

    reg_dump #(.DATA_W(DW), .ZERO_X31(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .rd_addr(rd_addr),
        .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_idx(m_idx), .m_data(m_data), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value the dump should capture for register i at this moment
    function automatic logic [DW-1:0] snap(input logic [4:0] i);
        return (i == 5'd31) ? '0 : regs[i];
    endfunction

    // Called at a negedge; returns at a negedge with the dump finished or aborted.
    // mode: 0 ready always, 1 random ready, 2 ready 1,0,0 pattern, 3 stall+write X2
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int abort_at, input bit poke, input bit abort_on_start);
        logic [4:0]    d, cur;
        logic [DW-1:0] exp_q [$];
        int            n, beats, cyc, pidx, stall_cnt;
        bit            rdy, aborted;
        d = l - f;
        n = int'(d) + 1;
        beats = 0; cyc = 1; pidx = 0; stall_cnt = 0; aborted = 0;
        start = 1'b1; first_reg = f; last_reg = l; abort = abort_on_start; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        first_reg = 5'($urandom); last_reg = 5'($urandom);
        chk("fetch_busy", busy, 1);
        chk("fetch_valid", m_valid, 0);
        chk("fetch_done", done, 0);
        chk("fetch_addr", rd_addr, f);
        exp_q.push_back(snap(f));
        while (beats < n && cyc < 400 && !aborted) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0;
            if (poke && cyc == 3) begin
                start = 1'b1; first_reg = f + 5'd3; last_reg = f + 5'd3;
            end
            chk("valid_held", m_valid, 1);
            if (!m_valid) break;
            cur = f + 5'(beats);
            chk("beat_idx", m_idx, cur);
            chk("beat_data", m_data, exp_q[beats]);
            chk("no_early_done", done, 0);
            if (mode == 3 && beats == 2) chk("write_seen", m_data, 64'hDEAD);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                2: begin rdy = (pidx % 3 == 0); pidx++; end
                default: begin
                    if (beats == 1 && stall_cnt < 3) begin
                        rdy = 1'b0;
                        if (stall_cnt == 0) regs[2] = 64'hDEAD;
                        stall_cnt++;
                    end else rdy = 1'b1;
                end
            endcase
            m_ready = rdy;
            if (abort_at == beats) begin abort = 1'b1; aborted = 1; end
            if (rdy) begin
                beats++;
                cur = f + 5'(beats);
                if (beats < n) exp_q.push_back(snap(cur));
            end
        end
        @(negedge clk);
        cyc++;
        start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        if (aborted) begin
            chk("abort_valid", m_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            @(negedge clk);
            chk("abort_done_later", done, 0);
        end else begin
            chk("beat_count", beats, n);
            chk("done_pulse", done, 1);
            chk("end_valid", m_valid, 0);
            chk("end_busy", busy, 0);
            if (mode == 0) chk("done_cycle", cyc, n + 2);
            if (beats != n) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        first_reg = '0; last_reg = '0;
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        repeat (3) @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", m_idx, 0);
        chk("rst_data", m_data, 0);
        chk("rst_addr", rd_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        run_dump(5'd0, 5'd31, 0, -1, 0, 0);   // full dump
        run_dump(5'd30, 5'd1, 0, -1, 0, 0);   // back-to-back, wrap
        run_dump(5'd5, 5'd5, 0, -1, 0, 0);    // single beat
        @(negedge clk);
        run_dump(5'd4, 5'd7, 2, -1, 0, 0);    // backpressure
        @(negedge clk);
        run_dump(5'd0, 5'd3, 3, -1, 0, 0);    // write during stall
        @(negedge clk);
        run_dump(5'd10, 5'd17, 0, 2, 1, 0);   // abort after 2, poke start while busy
        run_dump(5'd10, 5'd17, 1, -1, 0, 0);  // re-start after abort
        @(negedge clk);
        run_dump(5'd3, 5'd9, 1, -1, 0, 1);    // start+abort in IDLE: start wins

        // reset during SEND
        @(negedge clk);
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", m_idx, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_addr", rd_addr, 0);
        rst = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        run_dump(5'd28, 5'd3, 0, -1, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            run_dump(5'($urandom), 5'($urandom), int'($urandom_range(0, 2)), -1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
